// File: rtl/pc_branch_unit.sv
// Program-counter unit: registered fetch address with a loadable signed/absolute
// offset LUT and a small LIFO return-address stack for CALL/RET.
module pc_branch_unit #(
  parameter int            D        = 12,
  parameter int            SW       = 4,
  parameter int            S        = 4,
  parameter logic [D-1:0]  RESET_PC = '0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   halt,
  input  logic                   branch_en,
  input  logic [2:0]             mode,
  input  logic [SW-1:0]          sel,
  input  logic                   lut_we,
  input  logic [SW-1:0]          lut_waddr,
  input  logic [D-1:0]           lut_wdata,
  output logic [D-1:0]           prog_ctr,
  output logic [D-1:0]           next_pc,
  output logic [$clog2(S+1)-1:0] sp,
  output logic                   ovf_err,
  output logic                   unf_err
);

  localparam int SPW    = $clog2(S + 1);
  localparam int SIW    = (S > 1) ? $clog2(S) : 1;
  localparam int SDEPTH = 2 ** SIW;
  localparam int DEPTH  = 2 ** SW;

  localparam logic [2:0] MODE_NEXT    = 3'b000;
  localparam logic [2:0] MODE_REL_IMM = 3'b001;
  localparam logic [2:0] MODE_REL_LUT = 3'b010;
  localparam logic [2:0] MODE_ABS_LUT = 3'b011;
  localparam logic [2:0] MODE_CALL    = 3'b100;
  localparam logic [2:0] MODE_RET     = 3'b101;

  localparam logic [SPW-1:0] SP_FULL = SPW'(S);

  logic [D-1:0] lut   [DEPTH];
  logic [D-1:0] stack [SDEPTH];

  logic [D-1:0]   pc_inc;
  logic [D-1:0]   lut_rd;
  logic [SIW-1:0] push_idx;
  logic [SIW-1:0] pop_idx;
  logic           stack_full;
  logic           stack_empty;
  logic           do_push;
  logic           do_pop;
  logic           set_ovf;
  logic           set_unf;

  function automatic logic signed [D-1:0] sext_sel(input logic [SW-1:0] s);
    return {{(D - SW){s[SW-1]}}, s};
  endfunction

  // Two's-complement add; the carry out of bit D-1 is dropped, so it wraps.
  function automatic logic [D-1:0] add_wrap(input logic [D-1:0] base,
                                            input logic signed [D-1:0] off);
    return base + off;
  endfunction

  assign pc_inc      = prog_ctr + D'(1);
  assign lut_rd      = lut[sel];
  assign push_idx    = SIW'(sp);
  assign pop_idx     = SIW'(sp - SPW'(1));
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);

  always_comb begin
    next_pc = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (Reset) begin
      next_pc = RESET_PC;
    end else if (halt) begin
      next_pc = prog_ctr;
    end else if (branch_en) begin
      case (mode)
        MODE_NEXT:    next_pc = pc_inc;
        MODE_REL_IMM: next_pc = add_wrap(prog_ctr, sext_sel(sel));
        MODE_REL_LUT: next_pc = add_wrap(prog_ctr, lut_rd);
        MODE_ABS_LUT: next_pc = lut_rd;
        MODE_CALL: begin
          if (stack_full) begin
            set_ovf = 1'b1;
          end else begin
            do_push = 1'b1;
            next_pc = lut_rd;
          end
        end
        MODE_RET: begin
          if (stack_empty) begin
            set_unf = 1'b1;
          end else begin
            do_pop  = 1'b1;
            next_pc = stack[pop_idx];
          end
        end
        default:      next_pc = pc_inc;
      endcase
    end
  end

  // State update: PC follows next_pc; stack/flags frozen by halt, LUT writes are not.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prog_ctr <= RESET_PC;
      sp       <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
      for (int j = 0; j < SDEPTH; j++) stack[j] <= '0;
    end else begin
      prog_ctr <= next_pc;
      if (do_push) begin
        stack[push_idx] <= pc_inc;
        sp              <= sp + SPW'(1);
      end else if (do_pop) begin
        sp <= sp - SPW'(1);
      end
      if (set_ovf) ovf_err <= 1'b1;
      if (set_unf) unf_err <= 1'b1;
      if (lut_we) lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: a directed vector table for the documented corner
// cases, then randomized traffic checked against an abstract queue-based model.
module tb_pc_branch_unit;

  localparam int D  = 12;
  localparam int SW = 4;
  localparam int S  = 4;
  localparam int MASK = (1 << D) - 1;

  logic          Clk = 1'b0;
  logic          Reset, halt, branch_en, lut_we;
  logic [2:0]    mode;
  logic [SW-1:0] sel, lut_waddr;
  logic [D-1:0]  lut_wdata, prog_ctr, next_pc;
  logic [2:0]    sp;
  logic          ovf_err, unf_err;

  int total = 0;
  int bad   = 0;

  pc_branch_unit #(.D(D), .SW(SW), .S(S), .RESET_PC('0)) dut (
    .Clk(Clk), .Reset(Reset), .halt(halt), .branch_en(branch_en), .mode(mode),
    .sel(sel), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .next_pc(next_pc), .sp(sp),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit rst, hlt, be;
    int md, sl;
    bit we;
    int wa, wd;
    int pc, spv;
    bit ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit hlt, bit be, int md, int sl, bit we, int wa,
                              int wd, int pc, int spv, bit ovf, bit unf);
    vec_t v;
    v.rst = rst; v.hlt = hlt; v.be = be; v.md = md; v.sl = sl;
    v.we = we; v.wa = wa; v.wd = wd; v.pc = pc; v.spv = spv; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit hlt, input bit be, input int md, input int sl,
                       input bit we, input int wa, input int wd);
    Reset = rst; halt = hlt; branch_en = be; mode = 3'(md); sel = SW'(sl);
    lut_we = we; lut_waddr = SW'(wa); lut_wdata = D'(wd);
  endtask

  // Abstract reference state
  int m_pc, m_ovf, m_unf;
  int m_lut[16];
  int m_stk[$];

  function automatic int to_signed(int v, int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic int model_next(bit rst, bit hlt, bit be, int md, int sl);
    if (rst) return 0;
    if (hlt) return m_pc;
    if (!be) return (m_pc + 1) & MASK;
    case (md)
      1: return (m_pc + to_signed(sl, SW)) & MASK;
      2: return (m_pc + to_signed(m_lut[sl], D)) & MASK;
      3: return m_lut[sl];
      4: return (m_stk.size() < S) ? m_lut[sl] : (m_pc + 1) & MASK;
      5: return (m_stk.size() > 0) ? m_stk[$] : (m_pc + 1) & MASK;
      default: return (m_pc + 1) & MASK;
    endcase
  endfunction

  task automatic model_step(bit rst, bit hlt, bit be, int md, int sl, bit we, int wa, int wd);
    int nx;
    nx = model_next(rst, hlt, be, md, sl);
    if (rst) begin
      m_ovf = 0; m_unf = 0; m_stk.delete();
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      if (!hlt && be && md == 4) begin
        if (m_stk.size() < S) m_stk.push_back((m_pc + 1) & MASK);
        else m_ovf = 1;
      end
      if (!hlt && be && md == 5) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_unf = 1;
      end
      if (we) m_lut[wa] = wd;
    end
    m_pc = nx;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    //        rst hlt be md sl we wa wd        pc  sp ov un
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,      0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      2,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      3,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      4,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      5,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 20,     6,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 2, 0, 0, 0,      20, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 11, 0, 0, 0,     15, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 4, 4095,   16, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 4, 0, 0, 0,      4095, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,      0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 'hFFB,  1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 100,    2,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 5, 0, 0, 0,      100, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 3, 0, 0, 0,      95, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 3, 1, 3, 'h010,  90, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 3, 0, 0, 0,      106, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h200,  107, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 6, 50,     108, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 6, 0, 0, 0,      50, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0,      512, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0,      51, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0,      52, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 6, 0, 0, 0, 0,      53, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 7, 0, 0, 0, 0,      54, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0,      512, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      513, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0,      512, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      513, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      514, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0,      512, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      513, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      514, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      515, 3, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0,      512, 4, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0,      513, 4, 1, 1));
    tbl.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0,      516, 3, 1, 1));
    tbl.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0,      515, 2, 1, 1));
    tbl.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0,      514, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0,      55, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4, 1, 0, 0, 0,      55, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4, 1, 0, 0, 0,      55, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4, 1, 0, 0, 0,      55, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0,      512, 1, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8, 'h123,  512, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 3, 8, 0, 0, 0,      'h123, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 4, 1, 0, 0, 0,      0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 1, 0, 0, 0,      0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,      1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 0, 0, 0,      2,  0, 0, 1));

    foreach (tbl[k]) begin
      @(negedge Clk);
      drive(tbl[k].rst, tbl[k].hlt, tbl[k].be, tbl[k].md, tbl[k].sl,
            tbl[k].we, tbl[k].wa, tbl[k].wd);
      #1;
      check("vec_next_pc", k, int'(next_pc), tbl[k].pc);
      @(posedge Clk);
      #1;
      check("vec_prog_ctr", k, int'(prog_ctr), tbl[k].pc);
      check("vec_sp", k, int'(sp), tbl[k].spv);
      check("vec_ovf", k, int'(ovf_err), int'(tbl[k].ovf));
      check("vec_unf", k, int'(unf_err), int'(tbl[k].unf));
    end

    // Randomized traffic; first cycle forces a reset so model and DUT agree.
    m_pc = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rst, hlt, be, we;
      int md, sl, wa, wd, exp_nx;
      rst = (n == 0) || ($urandom_range(0, 99) == 0);
      hlt = ($urandom_range(0, 7) == 0);
      be  = ($urandom_range(0, 3) != 0);
      md  = $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : $urandom_range(3, 5);
      sl  = $urandom_range(0, 15);
      we  = ($urandom_range(0, 2) == 0);
      wa  = $urandom_range(0, 15);
      wd  = $urandom_range(0, MASK);
      @(negedge Clk);
      drive(rst, hlt, be, md, sl, we, wa, wd);
      exp_nx = model_next(rst, hlt, be, md, sl);
      #1;
      check("rnd_next_pc", n, int'(next_pc), exp_nx);
      @(posedge Clk);
      model_step(rst, hlt, be, md, sl, we, wa, wd);
      #1;
      check("rnd_prog_ctr", n, int'(prog_ctr), m_pc);
      check("rnd_sp", n, int'(sp), m_stk.size());
      check("rnd_flags", n, int'({ovf_err, unf_err}), (m_ovf << 1) | m_unf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program-counter unit that merges the PC register with a runtime-writable, signed branch-offset LUT and a small hardware return-address stack. It sits between instruction decode and instruction memory: decode supplies a branch mode and a 4-bit-class selector, and the unit produces the registered fetch address every cycle. It replaces the fixed-constant offset table with a loadable table and adds absolute, call and return control flow.

## Interface
Parameters:
- D, 12, PC / address width in bits
- SW, 4, selector width; LUT depth is 2**SW entries of D bits
- S, 4, return-stack depth (entries), S >= 1
- RESET_PC, 0, PC value loaded by Reset

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- halt  input  1  hold PC this cycle; no LUT-independent state changes
- branch_en  input  1  1 = apply mode, 0 = sequential PC+1
- mode  input  3  branch mode (see Operation)
- sel  input  SW  immediate offset (REL_IMM) or LUT index
- lut_we  input  1  LUT write enable
- lut_waddr  input  SW  LUT write index
- lut_wdata  input  D  LUT write data (signed offset or absolute address)
- prog_ctr  output  D  registered current PC
- next_pc  output  D  combinational value PC will take at next edge
- sp  output  $clog2(S+1)  number of valid return-stack entries
- ovf_err  output  1  sticky: CALL attempted with full stack
- unf_err  output  1  sticky: RET attempted with empty stack

## Operation
- All PC arithmetic modulo 2**D; offsets are two's complement, wrap silently.
- Priority per cycle: Reset > halt > branch_en/mode > sequential.
- branch_en=0: next_pc = PC+1.
- branch_en=1, mode:
  - 000 NEXT: PC+1
  - 001 REL_IMM: PC + sign_extend(sel) to D bits
  - 010 REL_LUT: PC + lut[sel]
  - 011 ABS_LUT: lut[sel]
  - 100 CALL: if sp<S push PC+1, next_pc = lut[sel]; if sp==S no push, next_pc = PC+1, set ovf_err
  - 101 RET: if sp>0 pop, next_pc = popped value; if sp==0 next_pc = PC+1, set unf_err
  - 110, 111: reserved, behave as NEXT
- halt=1: next_pc = PC; stack, sp, error flags unchanged. LUT writes still honoured.
- LUT write: lut[lut_waddr] <= lut_wdata at edge when lut_we=1, independent of halt/mode.
- LUT read/write same index same cycle: read returns old contents; new value visible next cycle.
- Stack is LIFO; push writes entry[sp], pop reads entry[sp-1]. Stack contents not cleared by pop.
- Error flags sticky; cleared only by Reset.

## Timing
- Reset (sync): prog_ctr = RESET_PC, sp = 0, ovf_err = unf_err = 0, all LUT entries = 0, stack entries = 0. Reset mid-CALL/RET discards the operation.
- During Reset cycle next_pc output = RESET_PC.
- next_pc combinational from current inputs and state; prog_ctr <= next_pc each edge: one-cycle latency, one decision per cycle, no stall beyond halt.
- Error flags and sp update on the same edge as the offending/causing CALL/RET.
- Back-to-back CALL/RET allowed every cycle; CALL then RET returns to call-site+1 after 2 edges.

## Test plan
- Reset then 5 cycles branch_en=0 -> prog_ctr 0,1,2,3,4,5; sp=0, flags 0.
- PC=20, REL_IMM sel=4'b1011 -> prog_ctr 15; PC=4095 NEXT -> prog_ctr 0 (wrap).
- Write lut[3]=12'hFFB, next cycle REL_LUT sel=3 at PC=100 -> 95; same-cycle write lut[3]=12'h010 with REL_LUT sel=3 at PC=95 -> 90 (old value), following REL_LUT -> 106.
- lut[1]=12'h200; CALL sel=1 at PC=50 -> PC 0x200, sp=1; RET -> PC 51, sp=0; RET again -> PC 52, unf_err=1.
- S=4: five CALLs -> sp=4 after fourth, fifth yields PC+1 with ovf_err=1; four RETs unwind in LIFO order.
- halt=1 for 3 cycles during CALL request -> PC, sp constant; Reset asserted mid-sequence -> PC=RESET_PC, sp=0, flags cleared, lut entries 0.
